instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage in front of the control/decode block. Owns the PC, issues word reads to a
//  synchronous instruction memory (1-cycle read latency) and buffers the returned words in a
//  2-entry FIFO. Decode pulls instructions with a valid/ready handshake. Decode redirects
//  fetch for taken branches and jumps with an absolute byte-address target.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  IMEM_AW    6              instruction memory word-address width (depth = 2**IMEM_AW)
// PORTS
//  clk             in   1   clock; all state changes on the rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  start           in   1   leave IDLE and begin fetching at the current PC
//  halt            in   1   stop issuing new fetches; drain what is already in flight
//  redirect_valid  in   1   load PC with redirect_pc and flush all fetched or in-flight work
//  redirect_pc     in   32  redirect target, byte address
//  imem_rd         out  1   read strobe to instruction memory
//  imem_addr       out  IMEM_AW  word address, equal to PC[IMEM_AW+1:2]
//  imem_rdata      in   32  read data, valid in the cycle after imem_rd
//  ir_valid        out  1   FIFO head holds an instruction
//  ir              out  32  instruction word at the FIFO head
//  ir_pc           out  32  byte PC of ir
//  ir_ready        in   1   decode accepts the head (transfer when ir_valid & ir_ready)
//  busy            out  1   1 when state != IDLE
//  misalign_err    out  1   sticky: some redirect_pc had bits [1:0] != 0
// BEHAVIOUR
//  Reset values
//   - State = IDLE, PC = RESET_PC.
//   - FIFO is empty and the inflight flag and epoch are cleared.
//   - imem_rd, ir_valid, busy and misalign_err are 0; ir and ir_pc are 0.
//  Reset mid-operation
//   - Asserting rst_n low clears all state immediately (asynchronous).
//   - An imem_rdata return in the cycle after reset is ignored.
//  FSM states: IDLE, RUN, HALTED.
//   - IDLE -> RUN when start = 1. No fetch is issued in the cycle start is sampled.
//   - RUN -> HALTED when halt = 1. No imem_rd is issued in that cycle or later.
//     An in-flight read still completes into the FIFO, and the FIFO drains normally.
//   - HALTED -> RUN only on redirect_valid; this is a redirect as defined below.
//     start is ignored in RUN and HALTED.
//  Fetch issue (RUN only)
//   - imem_rd = 1 when (count + inflight - pop) < 2 and redirect_valid = 0.
//     count is the FIFO occupancy; pop = ir_valid & ir_ready.
//   - Each issue advances PC by 4, modulo 2**32. PC 32'hFFFF_FFFC wraps to 0.
//   - imem_addr wraps at the memory depth.
//   - Throughput: sustained 1 instruction per cycle while ir_ready = 1.
//  Latency
//   - imem_rd asserted in cycle N, data sampled at the end of cycle N+1.
//   - ir_valid is high from cycle N+2. The first ir_valid appears 3 cycles after start.
//  Response tagging
//   - inflight records the epoch and PC of the outstanding read.
//   - A response is written to the FIFO only if its epoch equals the current epoch;
//     otherwise it is discarded.
//  FIFO
//   - 2 entries of {ir, ir_pc}. ir and ir_pc are stable while ir_valid = 1 and ir_ready = 0.
//   - Full: no issue. A write and a pop in the same cycle are both honoured when full.
//   - Empty: ir_valid = 0; ir and ir_pc hold their last values.
//  Redirect (RUN or HALTED; ignored in IDLE)
//   - Takes priority over halt and over issue in the same cycle.
//   - Next edge: PC <= {redirect_pc[31:2], 2'b00}, epoch toggles, FIFO is cleared,
//     and state goes to RUN.
//   - If ir_valid & ir_ready in the redirect cycle, that head counts as consumed.
//     All other entries are dropped.
//   - The first fetch from the new PC is issued in the cycle after the redirect.
//   - If redirect_pc[1:0] != 0, misalign_err is set; it stays set until reset.
//  Simultaneous halt and start in IDLE: go to RUN. halt is evaluated only in RUN.
// TESTING
//  1. Reset with RESET_PC = 0 and memory word k = 32'hA000_0000 + k; pulse start; ir_ready = 1.
//     -> ir = A0000000, A0000001, ... on consecutive cycles; ir_pc = 0, 4, 8;
//        first ir_valid 3 cycles after start.
//  2. Run with ir_ready held at 0. -> exactly 2 entries buffered and imem_rd = 0.
//     Release ir_ready. -> words 0 and 1, then 2, with no gap and no duplicate.
//  3. Issue redirect_pc = 32'h40 while the FIFO is full and a read is in flight.
//     -> next ir_pc = 32'h40 with ir = A0000010; stale words are never presented.
//  4. Redirect to 32'h42. -> misalign_err = 1 and ir_pc = 32'h40.
//     Also redirect to 32'hFFFF_FFF8 with IMEM_AW = 6.
//     -> ir_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; imem_addr 62, 63, 0.
//  5. Assert halt for 1 cycle in RUN. -> imem_rd = 0 from that cycle on; in-flight word still
//     delivered; state HALTED. Redirect to 32'h8. -> fetching resumes at ir_pc = 8.
//  6. Drop rst_n asynchronously mid-stream with the FIFO full.
//     -> ir_valid = 0 and imem_rd = 0 at once. After start, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency word reads to instruction memory and
// buffers returned words in a 2-entry FIFO presented to decode with a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               ir_valid,
    output logic [31:0]        ir,
    output logic [31:0]        ir_pc,
    input  logic               ir_ready,
    output logic               busy,
    output logic               misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e      state_q;
    logic        busy_q;
    logic        misalign_q;

    logic [31:0] pc_q, pc_d;
    logic        epoch_q, epoch_d;
    logic        infl_q, infl_d;
    logic        infl_epoch_q, infl_epoch_d;
    logic [31:0] infl_pc_q, infl_pc_d;

    // FIFO kept as a shift pair: entry 0 is always the head.
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] ent0_ir_q, ent0_ir_d, ent0_pc_q, ent0_pc_d;
    logic [31:0] ent1_ir_q, ent1_ir_d, ent1_pc_q, ent1_pc_d;

    logic        redir;
    logic        pop;
    logic [2:0]  level;
    logic        issue;
    logic [1:0]  cnt_mid;
    logic        rsp_ok;
    logic        push;

    assign redir    = redirect_valid && (state_q != S_IDLE);
    assign ir_valid = (cnt_q != 2'd0);
    assign pop      = ir_valid && ir_ready;
    assign level    = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue    = (state_q == S_RUN) && !redirect_valid && !halt && (level < 3'd2);
    assign cnt_mid  = cnt_q - {1'b0, pop};
    // A response from an older epoch, or one landing in a redirect cycle, is dropped.
    assign rsp_ok   = infl_q && (infl_epoch_q == epoch_q);
    assign push     = rsp_ok && !redir && (cnt_mid != 2'd2);

    assign imem_rd      = issue;
    assign imem_addr    = pc_q[IMEM_AW+1:2];
    assign ir           = ent0_ir_q;
    assign ir_pc        = ent0_pc_q;
    assign busy         = busy_q;
    assign misalign_err = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!redirect_valid && halt) state_q <= S_HALTED;
                end
                S_HALTED: begin
                    if (redirect_valid) state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (redir && (redirect_pc[1:0] != 2'b00)) misalign_q <= 1'b1;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        epoch_d      = epoch_q;
        infl_d       = issue;
        infl_epoch_d = infl_epoch_q;
        infl_pc_d    = infl_pc_q;
        if (redir) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            epoch_d = ~epoch_q;
        end else if (issue) begin
            pc_d         = pc_q + 32'd4;
            infl_epoch_d = epoch_q;
            infl_pc_d    = pc_q;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        ent0_ir_d = ent0_ir_q;
        ent0_pc_d = ent0_pc_q;
        ent1_ir_d = ent1_ir_q;
        ent1_pc_d = ent1_pc_q;
        if (redir) begin
            cnt_d = 2'd0;
        end else begin
            if (pop && (cnt_q == 2'd2)) begin
                ent0_ir_d = ent1_ir_q;
                ent0_pc_d = ent1_pc_q;
            end
            cnt_d = cnt_mid;
            if (push) begin
                if (cnt_mid == 2'd0) begin
                    ent0_ir_d = imem_rdata;
                    ent0_pc_d = infl_pc_q;
                end else begin
                    ent1_ir_d = imem_rdata;
                    ent1_pc_d = infl_pc_q;
                end
                cnt_d = cnt_mid + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            epoch_q      <= 1'b0;
            infl_q       <= 1'b0;
            infl_epoch_q <= 1'b0;
            infl_pc_q    <= 32'd0;
            cnt_q        <= 2'd0;
            ent0_ir_q    <= 32'd0;
            ent0_pc_q    <= 32'd0;
            ent1_ir_q    <= 32'd0;
            ent1_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            epoch_q      <= epoch_d;
            infl_q       <= infl_d;
            infl_epoch_q <= infl_epoch_d;
            infl_pc_q    <= infl_pc_d;
            cnt_q        <= cnt_d;
            ent0_ir_q    <= ent0_ir_d;
            ent0_pc_q    <= ent0_pc_d;
            ent1_ir_q    <= ent1_ir_d;
            ent1_pc_q    <= ent1_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, checked against a
// transaction-level model (expected PC stream, outstanding-word count, mode).
module tb_instr_fetch_unit;

    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

    logic        clk, rst_n;
    logic        start, halt, redirect_valid, ir_ready;
    logic [31:0] redirect_pc;
    logic        imem_rd;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir, ir_pc;
    logic        busy, misalign_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_mode;
    logic [31:0] iss_pc, exp_pc;
    int          outst;
    int          pop_total;
    logic        mis;
    logic        hold;
    logic [31:0] h_ir, h_pc;

    instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .busy(busy), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wexp(input logic [31:0] pc);
        return 32'hA000_0000 + {26'd0, pc[7:2]};
    endfunction

    // synchronous memory, word k = A000_0000 + k
    initial imem_rdata = 32'd0;
    always_ff @(posedge clk) if (imem_rd) imem_rdata <= wexp({24'd0, imem_addr, 2'b00});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (ir_valid) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        drv();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        drv();
        redirect_valid = 1'b0;
    endtask

    task automatic pulse_start();
        drv();
        start = 1'b1;
        drv();
        start = 1'b0;
    endtask

    // Monitor: per-cycle checks and model update for the coming edge.
    initial begin
        bit pop, redir, want_rd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_mode = M_IDLE; iss_pc = 32'd0; exp_pc = 32'd0;
                outst = 0; mis = 1'b0; hold = 1'b0;
            end else begin
                pop   = ir_valid && ir_ready;
                redir = redirect_valid && (m_mode != M_IDLE);
                chk("busy", busy, m_mode != M_IDLE);
                chk("misalign", misalign_err, mis);
                if (hold) begin
                    chk("hold_valid", ir_valid, 1'b1);
                    chk("hold_ir", ir, h_ir);
                    chk("hold_pc", ir_pc, h_pc);
                end
                want_rd = (m_mode == M_RUN) && !redirect_valid && !halt && ((outst - int'(pop)) < 2);
                chk("imem_rd", imem_rd, want_rd);
                if (pop) begin
                    chk("ir_pc", ir_pc, exp_pc);
                    chk("ir", ir, wexp(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    outst--;
                    pop_total++;
                end
                if (imem_rd) begin
                    chk("imem_addr", imem_addr, iss_pc[7:2]);
                    iss_pc = iss_pc + 32'd4;
                    outst++;
                end
                hold = ir_valid && !ir_ready && !redir;
                h_ir = ir;
                h_pc = ir_pc;
                if (redir) begin
                    iss_pc = {redirect_pc[31:2], 2'b00};
                    exp_pc = {redirect_pc[31:2], 2'b00};
                    outst  = 0;
                    m_mode = M_RUN;
                    if (redirect_pc[1:0] != 2'b00) mis = 1'b1;
                end else if (m_mode == M_IDLE && start) begin
                    m_mode = M_RUN;
                end else if (m_mode == M_RUN && halt) begin
                    m_mode = M_HALTED;
                end
            end
        end
    end

    initial begin
        int lat, vcnt, p0, o0, na;
        logic [5:0] addrs [3];
        pop_total = 0;
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; ir_ready = 1'b0;
        #23 rst_n = 1'b1;

        // reset state
        smp();
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_imem_rd", imem_rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_misalign", misalign_err, 1'b0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);

        // start latency and streaming
        ir_ready = 1'b1;
        pulse_start();
        lat = 99;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (ir_valid) begin lat = k + 1; break; end
        end
        chk("first_valid_lat", lat, 3);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin smp(); if (ir_valid) vcnt++; end
        chk("stream_no_gap", vcnt, 10);

        // back-pressure: exactly two buffered, no fetch
        drv(); ir_ready = 1'b0;
        repeat (6) smp();
        chk("bp_imem_rd", imem_rd, 1'b0);
        chk("bp_ir_valid", ir_valid, 1'b1);
        chk("bp_outstanding", outst, 2);
        drv(); ir_ready = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin smp(); if (ir_valid) vcnt++; end
        chk("release_no_gap", vcnt, 4);

        // redirect while full
        drv(); ir_ready = 1'b0;
        repeat (5) smp();
        redirect_to(32'h40);
        ir_ready = 1'b1;
        wait_valid("redir40");
        chk("redir40_pc", ir_pc, 32'h40);
        chk("redir40_ir", ir, 32'hA000_0010);

        // misaligned redirect and address wrap
        redirect_to(32'h42);
        ir_ready = 1'b1;
        wait_valid("redir42");
        chk("redir42_pc", ir_pc, 32'h40);
        chk("redir42_err", misalign_err, 1'b1);
        redirect_to(32'hFFFF_FFF8);
        na = 0;
        for (int k = 0; k < 10 && na < 3; k++) begin
            smp();
            if (imem_rd) begin addrs[na] = imem_addr; na++; end
        end
        chk("wrap_addr_cnt", na, 3);
        chk("wrap_addr0", addrs[0], 6'd62);
        chk("wrap_addr1", addrs[1], 6'd63);
        chk("wrap_addr2", addrs[2], 6'd0);
        repeat (6) smp();

        // halt drains in-flight work then stops
        drv(); halt = 1'b1;
        smp();
        chk("halt_imem_rd", imem_rd, 1'b0);
        p0 = pop_total; o0 = outst;
        drv(); halt = 1'b0;
        repeat (6) smp();
        chk("halt_drained", pop_total - p0, o0);
        chk("halt_ir_valid", ir_valid, 1'b0);
        chk("halt_busy", busy, 1'b1);
        chk("halt_no_rd", imem_rd, 1'b0);
        redirect_to(32'h8);
        wait_valid("resume8");
        chk("resume8_pc", ir_pc, 32'h8);

        // async reset with FIFO full
        drv(); ir_ready = 1'b0;
        repeat (5) smp();
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_ir_valid", ir_valid, 1'b0);
        chk("arst_imem_rd", imem_rd, 1'b0);
        chk("arst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        ir_ready = 1'b1;
        pulse_start();
        wait_valid("restart");
        chk("restart_pc", ir_pc, 32'h0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            drv();
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
                @(posedge clk); #2 rst_n = 1'b1;
                continue;
            end
            ir_ready       = ($urandom_range(0, 9) < 7);
            start          = ($urandom_range(0, 19) == 0);
            halt           = ($urandom_range(0, 39) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
        end
        drv();
        start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; ir_ready = 1'b1;
        repeat (5) smp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
